s2p_shift_in: RTL and testbench



---
 rtl/s2p_shift_in_if.sv | 24 ++
 rtl/s2p_shift_in.sv | 146 ++++++++++++++
 tb/tb_s2p_shift_in.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/s2p_shift_in_if.sv
// s2p_shift_in_if: capture request/result bundle for s2p_shift_in.
// start/busy handshake plus valid-qualified data word.
interface s2p_shift_in_if #(
  parameter int DATA_BITS = 64
);
  logic                 start;
  logic                 busy;
  logic                 valid;
  logic [DATA_BITS-1:0] data;

  modport master (
    output start,
    input  busy,
    input  valid,
    input  data
  );

  modport slave (
    input  start,
    output busy,
    output valid,
    output data
  );
endinterface

// File: rtl/s2p_shift_in.sv
// s2p_shift_in: drives a 74HC165-style chain (sh_ld_n, sh_clk), samples sdin
// and returns one DATA_BITS word per start on bus (busy, valid, data).
module s2p_shift_in #(
  parameter int DATA_BITS = 64,
  parameter int CLK_DIV   = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  s2p_shift_in_if.slave    bus,
  input  logic             sdin,
  output logic             sh_ld_n,
  output logic             sh_clk
);

  localparam int PW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [PW-1:0] PLAST = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ld_q, ld_d;
  logic                 sck_q, sck_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] shifted;
  logic                 phase_end;

  assign sh_ld_n   = ld_q;
  assign sh_clk    = sck_q;
  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.data  = data_q;

  // sdin joins the word at the end that was not the first-sampled end
  assign shifted = MSB_FIRST
    ? {shreg_q[DATA_BITS-2:0], sdin}
    : {sdin, shreg_q[DATA_BITS-1:1]};

  assign phase_end = (phase_q == PLAST);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    ld_d    = ld_q;
    sck_d   = sck_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        ld_d    = 1'b1;
        sck_d   = 1'b0;
        busy_d  = 1'b0;
        if (bus.start) begin
          state_d = LOAD;
          ld_d    = 1'b0;
          busy_d  = 1'b1;
          phase_d = '0;
          bit_d   = '0;
          shreg_d = '0;
        end
      end
      LOAD: begin
        if (phase_end) begin
          phase_d = '0;
          ld_d    = 1'b1;
          state_d = LOW;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      LOW: begin
        if (phase_end) begin
          phase_d = '0;
          shreg_d = shifted;
          // final sample goes straight to data on the same edge
          if (bit_q == BLAST) begin
            state_d = DONE;
            data_d  = shifted;
            valid_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = HIGH;
            sck_d   = 1'b1;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      HIGH: begin
        if (phase_end) begin
          phase_d = '0;
          sck_d   = 1'b0;
          bit_d   = bit_q + BW'(1);
          state_d = LOW;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      ld_q    <= 1'b1;
      sck_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      ld_q    <= ld_d;
      sck_q   <= sck_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_s2p_shift_in.sv
// tb_s2p_shift_in: default and small (8b, div 2, LSB first) instances
// fed by 74HC165 chain models, results checked against a queue.
module tb_s2p_shift_in;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  s2p_shift_in_if #(.DATA_BITS(64)) bus0 ();
  s2p_shift_in_if #(.DATA_BITS(8))  bus1 ();

  logic ld0, sck0, sdin0;
  logic ld1, sck1, sdin1;

  s2p_shift_in #(
    .DATA_BITS(64), .CLK_DIV(4), .MSB_FIRST(1'b1)
  ) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .sdin(sdin0), .sh_ld_n(ld0), .sh_clk(sck0)
  );

  s2p_shift_in #(
    .DATA_BITS(8), .CLK_DIV(2), .MSB_FIRST(1'b0)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .sdin(sdin1), .sh_ld_n(ld1), .sh_clk(sck1)
  );

  // chain models: parallel load while ld low, shift on sh_clk rise
  logic [63:0] word0 = '0;
  logic [63:0] chain0 = '0;
  logic        p0 = 1'b0;
  logic [7:0]  word1 = '0;
  logic [7:0]  chain1 = '0;
  logic        p1 = 1'b0;

  assign sdin0 = chain0[63];
  assign sdin1 = chain1[0];

  always @(posedge clk) begin
    if (!ld0) chain0 <= word0;
    else if (sck0 && !p0) chain0 <= {chain0[62:0], 1'b0};
    p0 <= sck0;
    if (!ld1) chain1 <= word1;
    else if (sck1 && !p1) chain1 <= {1'b0, chain1[7:1]};
    p1 <= sck1;
  end

  logic [63:0] q0[$];
  logic [7:0]  q1[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // watch dut0 for ncyc cycles, optionally pulsing start/rst at given edges
  task automatic observe0(
    input  int          ncyc,
    input  int          start_at,
    input  int          rst_at,
    output int          rises,
    output int          ldlow,
    output int          valids,
    output int          vcyc,
    output logic [63:0] vdata,
    output bit          held,
    output logic [2:0]  rsnap,
    output logic [63:0] rdata
  );
    logic        prev;
    logic [63:0] old;
    prev   = sck0;
    old    = bus0.data;
    rises  = 0;
    ldlow  = 0;
    valids = 0;
    vcyc   = -1;
    vdata  = '0;
    held   = 1'b1;
    rsnap  = 3'b111;
    rdata  = '1;
    for (int i = 0; i < ncyc; i++) begin
      if (sck0 && !prev) rises++;
      prev = sck0;
      if (!ld0) ldlow++;
      if (bus0.valid) begin
        valids++;
        if (valids == 1) begin
          vcyc  = cyc;
          vdata = bus0.data;
        end
      end else if (valids == 0 && rst_at < 0 && bus0.data !== old) begin
        held = 1'b0;
      end
      if (cyc == rst_at) begin
        rsnap = {bus0.busy, sck0, ld0};
        rdata = bus0.data;
      end
      bus0.start = (cyc + 1 == start_at);
      rst = (cyc + 1 == rst_at);
      tick();
    end
    bus0.start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus0.start = 1'b1;
    bus1.start = 1'b1;
    repeat (3) tick();
    checks++;
    if (ld0 !== 1'b1) begin
      errors++; $display("FAIL reset_ld got %b want 1", ld0);
    end
    checks++;
    if (sck0 !== 1'b0) begin
      errors++; $display("FAIL reset_sck got %b want 0", sck0);
    end
    checks++;
    if (bus0.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b want 0", bus0.busy);
    end
    checks++;
    if (bus0.valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", bus0.valid);
    end
    checks++;
    if (bus0.data !== 64'h0) begin
      errors++; $display("FAIL reset_data got %h want 0", bus0.data);
    end
    checks++;
    if (bus1.busy !== 1'b0 || ld1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_small got busy=%b ld=%b want 0/1", bus1.busy, ld1);
    end
    rst = 1'b0;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    tick();
    checks++;
    if (bus0.busy !== 1'b0) begin
      errors++; $display("FAIL reset_nostart got busy=%b want 0", bus0.busy);
    end
  endtask

  task automatic test_default_capture;
    int rises, ldlow, valids, vcyc, e0;
    logic [63:0] vdata, exp;
    logic [63:0] rdata;
    logic [2:0] rsnap;
    bit held;
    word0 = 64'h8000_0000_0000_0001;
    q0.push_back(word0);
    bus0.start = 1'b1;
    e0 = cyc + 1;
    tick();
    bus0.start = 1'b0;
    checks++;
    if (ld0 !== 1'b0 || bus0.busy !== 1'b1) begin
      errors++;
      $display("FAIL cap_start got ld=%b busy=%b want 0/1", ld0, bus0.busy);
    end
    observe0(520, -1, -1, rises, ldlow, valids, vcyc, vdata, held,
             rsnap, rdata);
    checks++;
    if (valids !== 1) begin
      errors++; $display("FAIL cap_valids got %0d want 1", valids);
    end
    checks++;
    if (vcyc - e0 !== 512) begin
      errors++; $display("FAIL cap_latency got %0d want 512", vcyc - e0);
    end
    checks++;
    if (rises !== 63) begin
      errors++; $display("FAIL cap_sck_rises got %0d want 63", rises);
    end
    checks++;
    if (ldlow !== 4) begin
      errors++; $display("FAIL cap_ld_low got %0d want 4", ldlow);
    end
    checks++;
    if (!held) begin
      errors++; $display("FAIL cap_data_held got changed want held");
    end
    checks++;
    if (q0.size() == 0) begin
      errors++; $display("FAIL cap_queue got empty want entry");
    end else begin
      exp = q0.pop_front();
      if (vdata !== exp) begin
        errors++; $display("FAIL cap_data got %h want %h", vdata, exp);
      end
    end
  endtask

  task automatic test_small_lsb;
    int rises, valids, vcyc, e0;
    logic prev;
    logic [7:0] vdata, exp;
    word1 = 8'h0D;
    q1.push_back(word1);
    bus1.start = 1'b1;
    e0 = cyc + 1;
    tick();
    bus1.start = 1'b0;
    rises = 0;
    valids = 0;
    vcyc = -1;
    vdata = '0;
    prev = sck1;
    for (int i = 0; i < 40; i++) begin
      if (sck1 && !prev) rises++;
      prev = sck1;
      if (bus1.valid) begin
        valids++;
        if (valids == 1) begin
          vcyc = cyc;
          vdata = bus1.data;
        end
      end
      tick();
    end
    checks++;
    if (valids !== 1 || vcyc - e0 !== 32) begin
      errors++;
      $display("FAIL small_valid got n=%0d at %0d want 1 at 32",
               valids, vcyc - e0);
    end
    checks++;
    if (rises !== 7) begin
      errors++; $display("FAIL small_rises got %0d want 7", rises);
    end
    checks++;
    if (q1.size() == 0) begin
      errors++; $display("FAIL small_queue got empty want entry");
    end else begin
      exp = q1.pop_front();
      if (vdata !== exp) begin
        errors++; $display("FAIL small_data got %h want %h", vdata, exp);
      end
    end
  endtask

  task automatic test_start_busy;
    int rises, ldlow, valids, vcyc, e0;
    logic [63:0] vdata, exp;
    logic [63:0] rdata;
    logic [2:0] rsnap;
    bit held;
    word0 = 64'hDEAD_BEEF_0BAD_F00D;
    q0.push_back(word0);
    bus0.start = 1'b1;
    e0 = cyc + 1;
    tick();
    bus0.start = 1'b0;
    observe0(530, e0 + 100, -1, rises, ldlow, valids, vcyc, vdata, held,
             rsnap, rdata);
    checks++;
    if (valids !== 1 || vcyc - e0 !== 512) begin
      errors++;
      $display("FAIL busy_start got n=%0d at %0d want 1 at 512",
               valids, vcyc - e0);
    end
    checks++;
    if (!held) begin
      errors++; $display("FAIL busy_data_held got changed want held");
    end
    checks++;
    if (ldlow !== 4) begin
      errors++; $display("FAIL busy_ld_low got %0d want 4", ldlow);
    end
    checks++;
    if (q0.size() == 0) begin
      errors++; $display("FAIL busy_queue got empty want entry");
    end else begin
      exp = q0.pop_front();
      if (vdata !== exp) begin
        errors++; $display("FAIL busy_data got %h want %h", vdata, exp);
      end
    end
  endtask

  task automatic test_reset_abort;
    int rises, ldlow, valids, vcyc, e0;
    logic [63:0] vdata, exp;
    logic [63:0] rdata;
    logic [2:0] rsnap;
    bit held;
    word0 = 64'h1234_5678_9ABC_DEF0;
    q0.push_back(word0);
    bus0.start = 1'b1;
    e0 = cyc + 1;
    tick();
    bus0.start = 1'b0;
    observe0(300, -1, e0 + 200, rises, ldlow, valids, vcyc, vdata, held,
             rsnap, rdata);
    checks++;
    if (valids !== 0) begin
      errors++; $display("FAIL abort_valid got %0d want 0", valids);
    end
    checks++;
    if (rsnap !== 3'b001) begin
      errors++;
      $display("FAIL abort_idle got busy,sck,ld=%b want 001", rsnap);
    end
    checks++;
    if (rdata !== 64'h0) begin
      errors++; $display("FAIL abort_data got %h want 0", rdata);
    end
    q0.delete();
    word0 = 64'h0F0F_3C3C_5A5A_9669;
    q0.push_back(word0);
    bus0.start = 1'b1;
    e0 = cyc + 1;
    tick();
    bus0.start = 1'b0;
    observe0(520, -1, -1, rises, ldlow, valids, vcyc, vdata, held,
             rsnap, rdata);
    checks++;
    if (valids !== 1 || vcyc - e0 !== 512) begin
      errors++;
      $display("FAIL abort_recap got n=%0d at %0d want 1 at 512",
               valids, vcyc - e0);
    end
    checks++;
    if (q0.size() == 0) begin
      errors++; $display("FAIL abort_queue got empty want entry");
    end else begin
      exp = q0.pop_front();
      if (vdata !== exp) begin
        errors++; $display("FAIL abort_recap_data got %h want %h", vdata, exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    int nv, v1, v2, busylow;
    logic [63:0] exp;
    word0 = 64'hA5A5_A5A5_A5A5_A5A5;
    q0.push_back(word0);
    bus0.start = 1'b1;
    tick();
    nv = 0;
    v1 = -1;
    v2 = -1;
    busylow = 0;
    for (int i = 0; i < 1100 && nv < 2; i++) begin
      if (nv == 1 && !bus0.busy && !bus0.valid) busylow++;
      if (bus0.valid) begin
        nv++;
        if (nv == 1) begin
          v1 = cyc;
          if (!bus0.busy) busylow++;
        end else begin
          v2 = cyc;
          bus0.start = 1'b0;
        end
        checks++;
        if (q0.size() == 0) begin
          errors++; $display("FAIL b2b_queue got empty want entry");
        end else begin
          exp = q0.pop_front();
          if (bus0.data !== exp) begin
            errors++;
            $display("FAIL b2b_data got %h want %h", bus0.data, exp);
          end
        end
        if (nv == 1) begin
          word0 = 64'h0123_4567_89AB_CDEF;
          q0.push_back(word0);
        end
      end
      if (nv < 2) tick();
    end
    bus0.start = 1'b0;
    checks++;
    if (nv !== 2 || v2 - v1 !== 513) begin
      errors++;
      $display("FAIL b2b_spacing got n=%0d gap=%0d want 2 gap=513",
               nv, v2 - v1);
    end
    checks++;
    if (busylow !== 1) begin
      errors++; $display("FAIL b2b_busy_gap got %0d want 1", busylow);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    test_reset();
    test_default_capture();
    test_small_lsb();
    test_start_busy();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
